// File: rtl/wb_master_engine.sv
// wb_master_engine: Wishbone classic-cycle master with a command FIFO.
// Commands are buffered, issued one bus cycle at a time, and each cycle
// produces exactly one response (data, slave error or ack timeout).
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command push handshake (ready = FIFO not full)
//   cmd_we/adr/dat/sel            command payload
//   cmd_level                     FIFO occupancy, 0..DEPTH
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat/rsp_err/rsp_timeout   response payload
//   wb_adr_o..wb_cyc_o            registered bus request
//   wb_dat_i/wb_ack_i/wb_err_i    slave response
module wb_master_engine #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [AW-1:0]            cmd_adr,
    input  logic [DW-1:0]            cmd_dat,
    input  logic [DW/8-1:0]          cmd_sel,
    output logic [$clog2(DEPTH):0]   cmd_level,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_dat,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic [AW-1:0]            wb_adr_o,
    output logic [DW-1:0]            wb_dat_o,
    output logic [DW/8-1:0]          wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic [DW-1:0]            wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic [AW-1:0]    fifo_adr [DEPTH];
    logic [DW-1:0]    fifo_dat [DEPTH];
    logic [SW-1:0]    fifo_sel [DEPTH];
    logic             fifo_we  [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    logic             push, pop;

    logic [AW-1:0]    adr_nxt;
    logic [DW-1:0]    dat_nxt;
    logic [SW-1:0]    sel_nxt;
    logic             we_nxt, stb_nxt, cyc_nxt;
    logic             rsp_valid_nxt, rsp_err_nxt, rsp_to_nxt;
    logic [DW-1:0]    rsp_dat_nxt;

    // FIFO full flag straight from the occupancy counter
    assign cmd_ready = (cmd_level != LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    // Command storage; payload needs no reset
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_adr[wr_ptr] <= cmd_adr;
            fifo_dat[wr_ptr] <= cmd_dat;
            fifo_sel[wr_ptr] <= cmd_sel;
            fifo_we[wr_ptr]  <= cmd_we;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cmd_level <= cmd_level + LW'(1);
                2'b01:   cmd_level <= cmd_level - LW'(1);
                default: cmd_level <= cmd_level;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_dat     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wb_adr_o    <= adr_nxt;
            wb_dat_o    <= dat_nxt;
            wb_sel_o    <= sel_nxt;
            wb_we_o     <= we_nxt;
            wb_stb_o    <= stb_nxt;
            wb_cyc_o    <= cyc_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_to_nxt;
            rsp_dat     <= rsp_dat_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pop           = 1'b0;
        adr_nxt       = wb_adr_o;
        dat_nxt       = wb_dat_o;
        sel_nxt       = wb_sel_o;
        we_nxt        = wb_we_o;
        stb_nxt       = wb_stb_o;
        cyc_nxt       = wb_cyc_o;
        rsp_valid_nxt = rsp_valid;
        rsp_err_nxt   = rsp_err;
        rsp_to_nxt    = rsp_timeout;
        rsp_dat_nxt   = rsp_dat;

        case (state)
            ST_IDLE: begin
                if (cmd_level != '0) begin
                    pop       = 1'b1;
                    adr_nxt   = fifo_adr[rd_ptr];
                    dat_nxt   = fifo_dat[rd_ptr];
                    sel_nxt   = fifo_sel[rd_ptr];
                    we_nxt    = fifo_we[rd_ptr];
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_BUS;
                end
            end

            ST_BUS: begin
                // err outranks a simultaneous ack
                if (wb_err_i) begin
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_to_nxt    = 1'b0;
                    rsp_dat_nxt   = '0;
                    state_nxt     = ST_RESP;
                end else if (wb_ack_i) begin
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_to_nxt    = 1'b0;
                    rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
                    state_nxt     = ST_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_to_nxt    = 1'b1;
                    rsp_dat_nxt   = '0;
                    state_nxt     = ST_RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_engine.sv
// Self-checking bench for wb_master_engine: directed vector table, FIFO
// full/ordering and reset sequences, then a randomized stream scored
// against a transaction-level reference model.
module tb_wb_master_engine;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [7:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_level;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    wb_master_engine #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .cmd_level(cmd_level),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        kind_e       kind;
        int          waits;
        logic [31:0] rdata;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_dat;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        to;
        logic [31:0] dat;
    } rsp_t;

    int tests;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response the slave outcome implies for a command
    function automatic rsp_t model_rsp(input cmd_t c, input kind_e k, input logic [31:0] rdata);
        rsp_t r;
        r.err = (k != K_ACK);
        r.to  = (k == K_NONE);
        r.dat = (k == K_ACK && !c.we) ? rdata : 32'h0;
        return r;
    endfunction

    function automatic int model_stb(input kind_e k, input int waits);
        return (k == K_NONE) ? int'(TIMEOUT) : waits + 1;
    endfunction

    task automatic drive_resp(input kind_e k, input logic [31:0] rdata);
        wb_ack_i = (k == K_ACK) || (k == K_BOTH);
        wb_err_i = (k == K_ERR) || (k == K_BOTH);
        wb_dat_i = rdata;
    endtask

    // One isolated command through push, bus cycle and response
    task automatic do_txn(input vec_t v, input int idx);
        int  lat;
        int  n;
        int  extra;
        bit  bus_ok;
        $display("[TB] vector %0d adr=0x%0h we=%0d", idx, v.adr, v.we);
        @(negedge clk);
        check("cmd_ready_before_push", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("level_after_push", 64'(cmd_level), 64'(1));
        lat = 0;
        while (!wb_cyc_o && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("pop_latency", 64'(lat), 64'(1));
        n = 0;
        bus_ok = 1'b1;
        while (wb_stb_o && n < int'(TIMEOUT) + 4) begin
            if (!wb_cyc_o || wb_adr_o !== v.adr || wb_we_o !== v.we ||
                wb_sel_o !== v.sel || wb_dat_o !== v.dat)
                bus_ok = 1'b0;
            n++;
            if (v.kind != K_NONE && n == v.waits + 1)
                drive_resp(v.kind, v.rdata);
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
        check("bus_fields_stable", 64'(bus_ok), 64'(1));
        check("stb_cycles", 64'(n), 64'(v.exp_stb));
        check("cyc_dropped", 64'(wb_cyc_o), 64'(0));
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_fields", {31'h0, rsp_err, rsp_timeout, rsp_dat},
              {31'h0, v.exp_err, v.exp_to, v.exp_dat});
        // stray ack right after the cycle must be ignored
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBAD0BAD0;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("rsp_held", {30'h0, rsp_valid, rsp_err, rsp_timeout, rsp_dat},
              {30'h0, 1'b1, v.exp_err, v.exp_to, v.exp_dat});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_falls", 64'(rsp_valid), 64'(0));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o) extra++;
        end
        check("no_extra_activity", 64'(extra), 64'(0));
    endtask

    // DEPTH=4, rsp_ready stalled: six reads, ready/level tracking and order
    task automatic fifo_full_test();
        int   pushed;
        int   got;
        int   exp_level;
        bit   hs;
        bit   prev_cyc;
        bit   saw_full;
        pushed = 0; got = 0; exp_level = 0; hs = 1'b0; prev_cyc = 1'b0; saw_full = 1'b0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (hs) exp_level++;
            if (wb_cyc_o && !prev_cyc) exp_level--;
            prev_cyc = wb_cyc_o;
            check("ff_level", 64'(cmd_level), 64'(exp_level));
            check("ff_cmd_ready", 64'(cmd_ready), 64'(cmd_level != 3'd4));
            if (cmd_level == 3'd4) saw_full = 1'b1;
            if (c == 19) begin
                check("ff_pushed_while_stalled", 64'(pushed), 64'(5));
                check("ff_full_reached", 64'(saw_full), 64'(1));
            end
            if (c >= 20) rsp_ready = 1'b1;
            if (rsp_valid && rsp_ready) begin
                check("ff_order", {31'h0, rsp_err, rsp_dat}, {31'h0, 1'b0, 24'h5A5A5A, 8'(got)});
                got++;
            end
            wb_ack_i = wb_stb_o;
            wb_dat_i = {24'h5A5A5A, wb_adr_o};
            cmd_valid = (pushed < 6);
            cmd_we = 1'b0; cmd_adr = 8'(pushed); cmd_dat = 32'h0; cmd_sel = 4'hF;
            hs = cmd_valid && cmd_ready;
            if (hs) pushed++;
        end
        cmd_valid = 1'b0;
        wb_ack_i = 1'b0;
        rsp_ready = 1'b0;
        check("ff_all_responses", 64'(got), 64'(6));
    endtask

    // Reset pulse while a cycle is active and two commands wait
    task automatic reset_test();
        int rsp_seen;
        int cyc_seen;
        wb_ack_i = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h30 + 8'(i); cmd_sel = 4'hF;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_pre_cyc", 64'(wb_cyc_o), 64'(1));
        check("rst_pre_level", 64'(cmd_level), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_cyc_low", {62'h0, wb_cyc_o, wb_stb_o}, 64'h0);
        check("rst_level", 64'(cmd_level), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        rsp_seen = 0; cyc_seen = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (wb_cyc_o) cyc_seen++;
            wb_ack_i = wb_stb_o;
        end
        wb_ack_i = 1'b0;
        rsp_ready = 1'b0;
        check("rst_no_responses", 64'(rsp_seen), 64'(0));
        check("rst_no_cycles", 64'(cyc_seen), 64'(0));
    endtask

    // Random traffic against a queue-based model
    task automatic run_stream(input int n_cmds);
        cmd_t  cmd_q[$];
        rsp_t  exp_q[$];
        cmd_t  cur;
        cmd_t  nc;
        rsp_t  er;
        kind_e kind;
        int    waits;
        int    stb_n;
        int    issued;
        int    exp_level;
        int    r;
        bit    in_bus;
        bit    hs;
        bit    held;
        bit    done;
        logic [31:0] rdata;
        logic [33:0] held_val;
        issued = 0; exp_level = 0; in_bus = 1'b0; hs = 1'b0; held = 1'b0; done = 1'b0;
        stb_n = 0; waits = 0; kind = K_ACK; rdata = '0; held_val = '0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (hs) exp_level++;
            // bus side: new cycle takes the oldest pending command
            if (wb_cyc_o && !in_bus) begin
                exp_level--;
                in_bus = 1'b1;
                stb_n = 0;
                if (cmd_q.size() == 0) begin
                    check("rs_unexpected_cycle", 64'(1), 64'(0));
                    cur = '{1'b0, 8'h0, 32'h0, 4'h0};
                end else begin
                    cur = cmd_q.pop_front();
                end
                r = int'($urandom_range(0, 99));
                kind = (r < 60) ? K_ACK : (r < 75) ? K_ERR : (r < 87) ? K_BOTH : K_NONE;
                waits = int'($urandom_range(0, 4));
                rdata = $urandom;
                exp_q.push_back(model_rsp(cur, kind, rdata));
            end
            if (in_bus) begin
                if (wb_stb_o) begin
                    stb_n++;
                    check("rs_bus", {19'h0, wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o},
                          {19'h0, 1'b1, cur.we, cur.adr, cur.sel, cur.dat});
                    if (kind != K_NONE && stb_n == waits + 1)
                        drive_resp(kind, rdata);
                end else begin
                    in_bus = 1'b0;
                    check("rs_stb_len", 64'(stb_n), 64'(model_stb(kind, waits)));
                end
            end else if ($urandom_range(0, 9) < 2) begin
                wb_ack_i = 1'b1;
                wb_dat_i = $urandom;
            end
            check("rs_level", 64'(cmd_level), 64'(exp_level));
            check("rs_cmd_ready", 64'(cmd_ready), 64'(exp_level != int'(DEPTH)));
            // response side
            if (held)
                check("rs_rsp_stable", {29'h0, rsp_valid, rsp_err, rsp_timeout, rsp_dat},
                      {29'h0, 1'b1, held_val});
            rsp_ready = ($urandom_range(0, 9) < 6);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rs_unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    er = exp_q.pop_front();
                    check("rs_rsp", {30'h0, rsp_err, rsp_timeout, rsp_dat},
                          {30'h0, er.err, er.to, er.dat});
                end
            end
            held = rsp_valid && !rsp_ready;
            held_val = {rsp_err, rsp_timeout, rsp_dat};
            // command side
            cmd_valid = (issued < n_cmds) && ($urandom_range(0, 1) == 1);
            nc.we = 1'(($urandom >> 3) & 1);
            nc.adr = 8'($urandom);
            nc.dat = $urandom;
            nc.sel = 4'($urandom);
            cmd_we = nc.we; cmd_adr = nc.adr; cmd_dat = nc.dat; cmd_sel = nc.sel;
            hs = cmd_valid && cmd_ready;
            if (hs) begin
                cmd_q.push_back(nc);
                issued++;
            end
            if (issued == n_cmds && !hs && cmd_q.size() == 0 && exp_q.size() == 0 &&
                !in_bus && !rsp_valid && !wb_cyc_o && cmd_level == 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("rs_completed", 64'(done), 64'(1));
    endtask

    vec_t vecs [8];

    initial begin
        tests = 0;
        errors = 0;
        vecs[0] = '{1'b0, 8'h40, 32'h0,        4'hF, K_ACK,  0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1};
        vecs[1] = '{1'b1, 8'h08, 32'h12345678, 4'h3, K_ACK,  3, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        4};
        vecs[2] = '{1'b0, 8'h10, 32'h0,        4'hF, K_ERR,  1, 32'h11111111, 1'b1, 1'b0, 32'h0,        2};
        vecs[3] = '{1'b0, 8'h11, 32'h0,        4'hF, K_BOTH, 0, 32'h55AA55AA, 1'b1, 1'b0, 32'h0,        1};
        vecs[4] = '{1'b0, 8'h20, 32'h0,        4'hF, K_NONE, 0, 32'h0,        1'b1, 1'b1, 32'h0,        16};
        vecs[5] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 4'hC, K_ERR,  2, 32'h77777777, 1'b1, 1'b0, 32'h0,        3};
        vecs[6] = '{1'b0, 8'h01, 32'h0,        4'h1, K_ACK,  5, 32'h000000C3, 1'b0, 1'b0, 32'h000000C3, 6};
        vecs[7] = '{1'b1, 8'h7E, 32'hCAFEF00D, 4'hF, K_NONE, 0, 32'h0,        1'b1, 1'b1, 32'h0,        16};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_cyc_stb_we", {61'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'h0);
        check("reset_adr", 64'(wb_adr_o), 64'h0);
        check("reset_dat", 64'(wb_dat_o), 64'h0);
        check("reset_sel", 64'(wb_sel_o), 64'h0);
        check("reset_rsp_flags", {61'h0, rsp_valid, rsp_err, rsp_timeout}, 64'h0);
        check("reset_rsp_dat", 64'(rsp_dat), 64'h0);
        check("reset_level", 64'(cmd_level), 64'h0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'h1);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i], i);

        fifo_full_test();
        repeat (4) @(negedge clk);
        reset_test();
        repeat (2) @(negedge clk);
        run_stream(60);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
